// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: FIFO of pending register writes draining into the regfile write port,
// with youngest-match forwarding of queued values to both read ports.
module regfile_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [ADDR_WIDTH-1:0]      InRegister,
  input  logic [DATA_WIDTH-1:0]      InData,
  input  logic                       WbHold,
  output logic                       RegWrite,
  output logic [ADDR_WIDTH-1:0]      WriteRegister,
  output logic [DATA_WIDTH-1:0]      WriteData,
  input  logic [ADDR_WIDTH-1:0]      FwdRegister1,
  input  logic [ADDR_WIDTH-1:0]      FwdRegister2,
  output logic                       FwdHit1,
  output logic                       FwdHit2,
  output logic [DATA_WIDTH-1:0]      FwdData1,
  output logic [DATA_WIDTH-1:0]      FwdData2,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] reg_q [DEPTH];
  logic [ADDR_WIDTH-1:0] reg_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;
  assign Count = count_q;
  always_comb begin
    InReady       = count_q < CW'(DEPTH);
    Empty         = count_q == '0;
    RegWrite      = !Empty && !WbHold;
    WriteRegister = Empty ? '0 : reg_q[rd_ptr_q];
    WriteData     = Empty ? '0 : data_q[rd_ptr_q];
    push          = InValid && InReady && |InRegister;
    pop           = RegWrite;
    reg_d         = reg_q;
    data_d        = data_q;
    valid_d       = valid_q;
    if (pop) valid_d[rd_ptr_q] = 1'b0;
    if (push) begin
      reg_d[wr_ptr_q]   = InRegister;
      data_d[wr_ptr_q]  = InData;
      valid_d[wr_ptr_q] = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    FwdHit1  = 1'b0;
    FwdHit2  = 1'b0;
    FwdData1 = '0;
    FwdData2 = '0;
    idx      = '0;
    // Scan oldest to youngest so later matches override earlier ones.
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && |FwdRegister1 && reg_q[idx] == FwdRegister1) begin
        FwdHit1  = 1'b1;
        FwdData1 = data_q[idx];
      end
      if (valid_q[idx] && |FwdRegister2 && reg_q[idx] == FwdRegister2) begin
        FwdHit2  = 1'b1;
        FwdData2 = data_q[idx];
      end
    end
  end
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      reg_q    <= '{default: '0};
      data_q   <= '{default: '0};
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      reg_q    <= reg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: directed steps against a scoreboard of expected register-file writes.
module tb_regfile_writeback_queue;
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;
  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        InValid = 1'b0, InReady;
  logic [4:0]  InRegister = '0;
  logic [31:0] InData = '0;
  logic        WbHold = 1'b0, RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  FwdRegister1 = '0, FwdRegister2 = '0;
  logic        FwdHit1, FwdHit2;
  logic [31:0] FwdData1, FwdData2;
  logic [2:0]  Count;
  logic        Empty;
  ent_t        sb[$];
  int          mcount = 0;
  int          n = 0;
  int          nerr = 0;

  regfile_writeback_queue dut (
    .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .InRegister(InRegister), .InData(InData), .WbHold(WbHold),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .FwdRegister1(FwdRegister1), .FwdRegister2(FwdRegister2),
    .FwdHit1(FwdHit1), .FwdHit2(FwdHit2), .FwdData1(FwdData1), .FwdData2(FwdData2),
    .Count(Count), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] r, input logic [31:0] d, input logic h);
    InValid    = v;
    InRegister = r;
    InData     = d;
    WbHold     = h;
  endtask

  // Checks every output against the model mid-cycle, then advances one clock.
  task automatic tick();
    logic        do_push, do_pop, h1, h2;
    logic [31:0] d1, d2;
    #1;
    chk("count", 32'(Count), mcount);
    chk("ready", 32'(InReady), 32'(mcount < 4));
    chk("empty", 32'(Empty), 32'(mcount == 0));
    do_pop = (mcount != 0) && !WbHold;
    chk("regwrite", 32'(RegWrite), 32'(do_pop));
    if (mcount != 0) begin
      chk("wreg", 32'(WriteRegister), 32'(sb[0].r));
      chk("wdata", WriteData, sb[0].d);
    end else begin
      chk("wreg_empty", 32'(WriteRegister), 0);
      chk("wdata_empty", WriteData, 0);
    end
    h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    foreach (sb[i]) begin
      if (FwdRegister1 != 0 && sb[i].r == FwdRegister1) begin h1 = 1'b1; d1 = sb[i].d; end
      if (FwdRegister2 != 0 && sb[i].r == FwdRegister2) begin h2 = 1'b1; d2 = sb[i].d; end
    end
    chk("fwd_hit1", 32'(FwdHit1), 32'(h1));
    chk("fwd_data1", FwdData1, d1);
    chk("fwd_hit2", 32'(FwdHit2), 32'(h2));
    chk("fwd_data2", FwdData2, d2);
    do_push = InValid && (mcount < 4) && (InRegister != 0);
    @(negedge Clk);
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back('{r: InRegister, d: InData});
    mcount = mcount + int'(do_push) - int'(do_pop);
  endtask

  initial begin
    #3;
    chk("rst_count", 32'(Count), 0);
    chk("rst_ready", 32'(InReady), 1);
    chk("rst_empty", 32'(Empty), 1);
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_wdata", WriteData, 0);
    @(negedge Clk);
    ResetN = 1'b1;
    FwdRegister1 = 5'd3;
    drv(1, 5'd3, 32'h11111111, 0);
    tick();
    drv(0, 0, 0, 0);
    #1;
    chk("t1_wreg", 32'(WriteRegister), 3);
    chk("t1_hit", 32'(FwdHit1), 1);
    tick();
    tick();
    FwdRegister1 = 5'd5;
    FwdRegister2 = 5'd7;
    drv(1, 5'd5, 32'hA, 1); tick();
    drv(1, 5'd5, 32'hB, 1); tick();
    drv(1, 5'd7, 32'hC, 1); tick();
    drv(0, 0, 0, 1);
    #1;
    chk("t2_count", 32'(Count), 3);
    chk("t2_fwd1", FwdData1, 32'hB);
    chk("t2_fwd2", FwdData2, 32'hC);
    tick();
    drv(0, 0, 0, 0);
    repeat (4) tick();
    FwdRegister1 = 5'd2;
    FwdRegister2 = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      drv(1, 5'(i), $urandom, 1);
      tick();
    end
    drv(1, 5'd9, 32'h99999999, 1);
    #1;
    chk("t3_full_ready", 32'(InReady), 0);
    chk("t3_full_count", 32'(Count), 4);
    tick();
    drv(0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1);
    #1;
    chk("t3_count3", 32'(Count), 3);
    chk("t3_ready", 32'(InReady), 1);
    tick();
    drv(0, 0, 0, 0);
    repeat (4) tick();
    FwdRegister1 = 5'd0;
    FwdRegister2 = 5'd0;
    drv(1, 5'd0, 32'hDEADBEEF, 0);
    #1;
    chk("t4_ready", 32'(InReady), 1);
    tick();
    drv(0, 0, 0, 0);
    #1;
    chk("t4_count", 32'(Count), 0);
    chk("t4_regwrite", 32'(RegWrite), 0);
    repeat (2) tick();
    FwdRegister1 = 5'd6;
    FwdRegister2 = 5'd12;
    for (int i = 0; i < 12; i++) begin
      drv(1, 5'($urandom_range(1, 15)), $urandom, 0);
      tick();
    end
    drv(0, 0, 0, 0);
    repeat (2) tick();
    FwdRegister1 = 5'd20;
    FwdRegister2 = 5'd21;
    drv(1, 5'd20, 32'h20, 1); tick();
    drv(1, 5'd21, 32'h21, 1); tick();
    drv(1, 5'd22, 32'h22, 1); tick();
    drv(0, 0, 0, 0);
    #2;
    ResetN = 1'b0;
    #1;
    chk("t6_count", 32'(Count), 0);
    chk("t6_regwrite", 32'(RegWrite), 0);
    chk("t6_hit1", 32'(FwdHit1), 0);
    chk("t6_hit2", 32'(FwdHit2), 0);
    sb.delete();
    mcount = 0;
    @(negedge Clk);
    ResetN = 1'b1;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
    $finish;
  end
endmodule
